// File: rtl/xoodyak_sequencer_if.sv
// Command, block-stream and core-drive bundle between a command source and xoodyak_sequencer.
// master = command/stream source side, slave = sequencer side.
interface xoodyak_sequencer_if #(
    parameter int DATA_W = 352
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_mode;
    logic [3:0]        cmd_ad_blocks;
    logic [3:0]        cmd_txt_blocks;
    logic              data_valid;
    logic              data_ready;
    logic [DATA_W-1:0] data_in;
    logic [4:0]        core_opmode;
    logic [DATA_W-1:0] core_data;
    logic              busy;
    logic              done;

    modport master (
        output cmd_valid, cmd_mode, cmd_ad_blocks, cmd_txt_blocks, data_valid, data_in,
        input  cmd_ready, data_ready, core_opmode, core_data, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_mode, cmd_ad_blocks, cmd_txt_blocks, data_valid, data_in,
        output cmd_ready, data_ready, core_opmode, core_data, busy, done
    );
endinterface

// File: rtl/xoodyak_sequencer.sv
// Sequences one keyed encrypt/decrypt or hash transaction into xoodyak_build opmodes, each held OP_CLKS cycles.
// Data ops cost OP_CLKS+1 cycles (one LOAD handshake cycle); LOAD waits indefinitely on data_valid, no timeout.
module xoodyak_sequencer #(
    parameter int OP_CLKS = 12,
    parameter int DATA_W  = 352
) (
    input logic                eph1,
    input logic                reset,
    xoodyak_sequencer_if.slave bus
);
    localparam logic [7:0] SLOT_LAST = 8'(OP_CLKS - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ISSUE} state_t;
    typedef enum logic [2:0] {P_KEY, P_NONCE, P_AD, P_TXT, P_TAG, P_HINIT} phase_t;

    state_t            state_q, state_d;
    phase_t            phase_q, phase_d;
    logic [7:0]        slot_q, slot_d;
    logic [3:0]        ad_q, ad_d, txt_q, txt_d;
    logic [3:0]        ad_left, txt_left;
    logic              hash_q, hash_d, dec_q, dec_d, done_q, done_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              cmd_hash;
    logic [3:0]        func;

    // Reserved mode 3 runs as a hash.
    assign cmd_hash = (bus.cmd_mode == 2'd0) || (bus.cmd_mode == 2'd3);

    always_ff @(posedge eph1 or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            phase_q <= P_KEY;
            slot_q  <= '0;
            ad_q    <= '0;
            txt_q   <= '0;
            hash_q  <= 1'b0;
            dec_q   <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            slot_q  <= slot_d;
            ad_q    <= ad_d;
            txt_q   <= txt_d;
            hash_q  <= hash_d;
            dec_q   <= dec_d;
            done_q  <= done_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        slot_d   = slot_q;
        ad_d     = ad_q;
        txt_d    = txt_q;
        hash_d   = hash_q;
        dec_d    = dec_q;
        done_d   = 1'b0;
        data_d   = data_q;
        // Remaining block counts once the current op retires; never wrap below zero.
        ad_left  = (phase_q == P_AD  && ad_q  != 4'd0) ? ad_q  - 4'd1 : ad_q;
        txt_left = (phase_q == P_TXT && txt_q != 4'd0) ? txt_q - 4'd1 : txt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    hash_d = cmd_hash;
                    dec_d  = (bus.cmd_mode == 2'd2);
                    ad_d   = bus.cmd_ad_blocks;
                    txt_d  = cmd_hash ? 4'd0 : bus.cmd_txt_blocks;
                    slot_d = '0;
                    if (cmd_hash) begin
                        state_d = S_ISSUE;
                        phase_d = P_HINIT;
                        data_d  = '0;
                    end else begin
                        state_d = S_LOAD;
                        phase_d = P_KEY;
                    end
                end
            end
            S_LOAD: begin
                if (bus.data_valid) begin
                    data_d  = bus.data_in;
                    state_d = S_ISSUE;
                    slot_d  = '0;
                end
            end
            S_ISSUE: begin
                if (slot_q != SLOT_LAST) begin
                    slot_d = slot_q + 8'd1;
                end else begin
                    slot_d = '0;
                    ad_d   = ad_left;
                    txt_d  = txt_left;
                    if (phase_q == P_TAG) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else if (phase_q == P_KEY) begin
                        state_d = S_LOAD;
                        phase_d = P_NONCE;
                    end else if (ad_left != 4'd0) begin
                        state_d = S_LOAD;
                        phase_d = P_AD;
                    end else if (txt_left != 4'd0) begin
                        state_d = S_LOAD;
                        phase_d = P_TXT;
                    end else begin
                        state_d = S_ISSUE;
                        phase_d = P_TAG;
                        data_d  = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        func = 4'h0;
        case (phase_q)
            P_KEY:   func = 4'h1;
            P_NONCE: func = 4'h2;
            P_AD:    func = 4'h3;
            P_TXT:   func = dec_q ? 4'h5 : 4'h4;
            P_TAG:   func = 4'h6;
            default: func = 4'h0;
        endcase
    end

    assign bus.cmd_ready   = (state_q == S_IDLE) && !reset;
    assign bus.data_ready  = (state_q == S_LOAD);
    assign bus.core_opmode = (state_q == S_ISSUE) ? {hash_q, func} : 5'h00;
    assign bus.core_data   = data_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = done_q;
endmodule

// File: tb/tb_xoodyak_sequencer.sv
// Randomized scoreboard bench for xoodyak_sequencer: a transaction-level model queues expected ops and done events,
// an independent monitor pops and compares them as the DUT presents opmodes and done.
module tb_xoodyak_sequencer;
    localparam int OP_CLKS = 12;
    localparam int DATA_W  = 352;
    localparam int BOUND   = 4000;

    typedef logic [DATA_W-1:0] blk_t;
    typedef struct { logic [4:0] opmode; blk_t data; } op_t;
    typedef struct { int cyc; int hs; } done_t;

    logic eph1 = 1'b0;
    logic reset;
    int   cyc = 0;

    xoodyak_sequencer_if #(.DATA_W(DATA_W)) bus();

    xoodyak_sequencer #(.OP_CLKS(OP_CLKS), .DATA_W(DATA_W)) dut (
        .eph1  (eph1),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 eph1 = ~eph1;
    always @(posedge eph1) cyc <= cyc + 1;

    op_t   exp_op_q[$];
    done_t exp_done_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    bit    sb_off = 1'b0;
    bit    prev_keep = 1'b0;
    int    prev_pred_done = 0;

    // monitor state
    int    run_len = 0;
    op_t   cur;
    bit    hold_err = 1'b0;
    int    hs_cnt = 0;
    int    tag_end = -10;
    done_t de;

    function automatic blk_t rand_blk();
        blk_t b;
        for (int i = 0; i < 11; i++) b[i*32 +: 32] = $urandom();
        return b;
    endfunction

    task automatic chk(input string name, input blk_t act, input blk_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge eph1);
            #1;
            if (reset) begin
                run_len  = 0;
                hold_err = 1'b0;
                hs_cnt   = 0;
            end else if (!sb_off) begin
                if (bus.data_valid && bus.data_ready) hs_cnt++;
                if (bus.core_opmode != 5'h00) begin
                    if (run_len == 0) begin
                        vectors++;
                        hold_err = 1'b0;
                        if (exp_op_q.size() == 0) begin
                            miscompares++;
                            $display("FAIL unexpected_op @%0d: got opmode %h, nothing expected", cyc, bus.core_opmode);
                            cur.opmode = bus.core_opmode;
                            cur.data   = bus.core_data;
                        end else begin
                            cur = exp_op_q.pop_front();
                            if (bus.core_opmode !== cur.opmode || bus.core_data !== cur.data) begin
                                miscompares++;
                                $display("FAIL op_start @%0d: got opmode %h data %h, expected opmode %h data %h",
                                         cyc, bus.core_opmode, bus.core_data, cur.opmode, cur.data);
                            end
                        end
                    end else if (bus.core_opmode !== cur.opmode || bus.core_data !== cur.data) begin
                        hold_err = 1'b1;
                    end
                    run_len++;
                    if (run_len == OP_CLKS) begin
                        vectors++;
                        if (hold_err) begin
                            miscompares++;
                            $display("FAIL op_hold @%0d: opmode/data changed within op, expected %h held %0d cycles",
                                     cyc, cur.opmode, OP_CLKS);
                        end
                        if (cur.opmode[3:0] == 4'h6) tag_end = cyc;
                        run_len = 0;
                    end
                end else if (run_len != 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL op_short @%0d: opmode %h held %0d cycles, expected %0d", cyc, cur.opmode, run_len, OP_CLKS);
                    run_len = 0;
                end
                if (bus.done) begin
                    vectors++;
                    if (exp_done_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_done @%0d: got done=1, expected none", cyc);
                    end else begin
                        de = exp_done_q.pop_front();
                        if (cyc != de.cyc || hs_cnt != de.hs || tag_end != cyc - 1 || bus.busy !== 1'b0) begin
                            miscompares++;
                            $display("FAIL done: got cycle %0d handshakes %0d tag_end %0d busy %b, expected cycle %0d handshakes %0d tag_end %0d busy 0",
                                     cyc, hs_cnt, tag_end, bus.busy, de.cyc, de.hs, cyc - 1);
                        end
                    end
                    hs_cnt = 0;
                end
            end
        end
    end

    task automatic send_block(input blk_t b, input int stall);
        int n = 0;
        if (stall == 0) begin
            bus.data_in    = b;
            bus.data_valid = 1'b1;
        end else begin
            bus.data_valid = 1'b0;
        end
        while (!bus.data_ready && n < BOUND) begin
            @(negedge eph1);
            n++;
        end
        if (n == BOUND) begin
            vectors++;
            miscompares++;
            $display("FAIL data_ready_timeout: got no data_ready in %0d cycles, expected LOAD", BOUND);
            bus.data_valid = 1'b0;
            return;
        end
        if (stall > 0) begin
            repeat (stall) @(negedge eph1);
            bus.data_in    = b;
            bus.data_valid = 1'b1;
        end
        @(negedge eph1);
        // junk presented while the core op runs must be ignored
        bus.data_in    = rand_blk();
        bus.data_valid = 1'b1;
        repeat ($urandom_range(0, OP_CLKS - 3)) @(negedge eph1);
        bus.data_valid = 1'b0;
    endtask

    task automatic run_txn(input logic [1:0] mode, input int ad, input int txt,
                           input int stall_nonce, input bit rand_stall, input bit keep);
        blk_t  blks[$];
        int    stalls[$];
        blk_t  b;
        op_t   o;
        bit    hash;
        int    base, stall_sum, t, s;
        int    n = 0;
        hash = (mode == 2'd0) || (mode == 2'd3);
        if (hash) begin
            o.opmode = 5'h10; o.data = '0; exp_op_q.push_back(o);
            for (int i = 0; i < ad; i++) begin
                b = rand_blk(); blks.push_back(b);
                o.opmode = 5'h13; o.data = b; exp_op_q.push_back(o);
            end
            o.opmode = 5'h16; o.data = '0; exp_op_q.push_back(o);
            base = 2 * OP_CLKS + ad * (OP_CLKS + 1) + 1;
        end else begin
            for (int i = 0; i < 2 + ad + txt; i++) begin
                b = rand_blk(); blks.push_back(b);
                if (i == 0)           o.opmode = 5'h01;
                else if (i == 1)      o.opmode = 5'h02;
                else if (i < 2 + ad)  o.opmode = 5'h03;
                else                  o.opmode = (mode == 2'd2) ? 5'h05 : 5'h04;
                o.data = b;
                exp_op_q.push_back(o);
            end
            o.opmode = 5'h06; o.data = '0; exp_op_q.push_back(o);
            base = (2 + ad + txt) * (OP_CLKS + 1) + OP_CLKS + 1;
        end
        stall_sum = 0;
        for (int i = 0; i < blks.size(); i++) begin
            s = rand_stall ? int'($urandom_range(0, 4)) : 0;
            if (!hash && i == 1 && stall_nonce > 0) s = stall_nonce;
            stalls.push_back(s);
            stall_sum += s;
        end
        bus.cmd_mode       = mode;
        bus.cmd_ad_blocks  = 4'(ad);
        bus.cmd_txt_blocks = 4'(txt);
        bus.cmd_valid      = 1'b1;
        while (!bus.cmd_ready && n < BOUND) begin
            @(negedge eph1);
            n++;
        end
        if (n == BOUND) begin
            vectors++;
            miscompares++;
            $display("FAIL cmd_accept_timeout: got cmd_ready=0 for %0d cycles, expected accept", BOUND);
            bus.cmd_valid = 1'b0;
            return;
        end
        t = cyc;
        if (prev_keep) chk_int("b2b_accept_cycle", t, prev_pred_done);
        de.cyc = t + base + stall_sum;
        de.hs  = blks.size();
        exp_done_q.push_back(de);
        prev_pred_done = de.cyc;
        @(negedge eph1);
        if (!keep) bus.cmd_valid = 1'b0;
        for (int i = 0; i < blks.size(); i++) send_block(blks[i], stalls[i]);
        prev_keep = keep;
    endtask

    task automatic wait_quiet();
        int n = 0;
        bus.cmd_valid = 1'b0;
        prev_keep     = 1'b0;
        while ((exp_op_q.size() != 0 || exp_done_q.size() != 0) && n < BOUND) begin
            @(negedge eph1);
            n++;
        end
        if (n == BOUND) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d ops and %0d done events outstanding, expected 0", exp_op_q.size(), exp_done_q.size());
            exp_op_q.delete();
            exp_done_q.delete();
        end
        repeat ($urandom_range(1, 4)) @(negedge eph1);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bit keep;
        bus.cmd_valid      = 1'b0;
        bus.cmd_mode       = 2'd0;
        bus.cmd_ad_blocks  = 4'd0;
        bus.cmd_txt_blocks = 4'd0;
        bus.data_valid     = 1'b0;
        bus.data_in        = '0;
        reset              = 1'b1;
        #1;
        chk("rst_cmd_ready", blk_t'(bus.cmd_ready), '0);
        chk("rst_data_ready", blk_t'(bus.data_ready), '0);
        chk("rst_opmode", blk_t'(bus.core_opmode), '0);
        chk("rst_core_data", bus.core_data, '0);
        chk("rst_busy", blk_t'(bus.busy), '0);
        chk("rst_done", blk_t'(bus.done), '0);
        repeat (3) @(negedge eph1);
        reset = 1'b0;
        #1;
        chk("rel_cmd_ready", blk_t'(bus.cmd_ready), blk_t'(1));
        chk("rel_busy", blk_t'(bus.busy), '0);
        @(negedge eph1);

        run_txn(2'd1, 2, 2, 0, 1'b0, 1'b0);   wait_quiet();
        run_txn(2'd0, 3, 0, 0, 1'b0, 1'b0);   wait_quiet();
        run_txn(2'd2, 0, 1, 0, 1'b0, 1'b0);   wait_quiet();
        run_txn(2'd1, 1, 1, 5, 1'b0, 1'b0);   wait_quiet();
        run_txn(2'd1, 15, 15, 0, 1'b1, 1'b0); wait_quiet();
        run_txn(2'd0, 0, 0, 0, 1'b0, 1'b0);   wait_quiet();

        run_txn(2'd1, 2, 2, 0, 1'b0, 1'b1);
        run_txn(2'd0, 3, 0, 0, 1'b0, 1'b1);
        run_txn(2'd3, 0, 5, 0, 1'b0, 1'b1);
        run_txn(2'd2, 1, 0, 0, 1'b1, 1'b1);
        wait_quiet();

        for (int i = 0; i < 12; i++) begin
            keep = 1'($urandom_range(0, 1));
            run_txn(2'($urandom_range(0, 3)), int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                    0, 1'b1, keep);
            if (!keep && $urandom_range(0, 1) == 1) wait_quiet();
        end
        wait_quiet();

        sb_off             = 1'b1;
        bus.cmd_mode       = 2'd1;
        bus.cmd_ad_blocks  = 4'd2;
        bus.cmd_txt_blocks = 4'd1;
        bus.cmd_valid      = 1'b1;
        bus.data_in        = rand_blk();
        bus.data_valid     = 1'b1;
        n = 0;
        while (!bus.busy && n < BOUND) begin
            @(negedge eph1);
            n++;
        end
        bus.cmd_valid = 1'b0;
        while (bus.core_opmode != 5'h03 && n < BOUND) begin
            @(negedge eph1);
            n++;
        end
        chk_int("reach_ad_issue", (n < BOUND) ? 1 : 0, 1);
        repeat (3) @(negedge eph1);
        reset = 1'b1;
        #1;
        chk("midrst_cmd_ready", blk_t'(bus.cmd_ready), '0);
        chk("midrst_data_ready", blk_t'(bus.data_ready), '0);
        chk("midrst_opmode", blk_t'(bus.core_opmode), '0);
        chk("midrst_core_data", bus.core_data, '0);
        chk("midrst_busy", blk_t'(bus.busy), '0);
        chk("midrst_done", blk_t'(bus.done), '0);
        bus.data_valid = 1'b0;
        repeat (2) @(negedge eph1);
        reset = 1'b0;
        #1;
        chk("midrel_cmd_ready", blk_t'(bus.cmd_ready), blk_t'(1));
        chk("midrel_busy", blk_t'(bus.busy), '0);
        @(negedge eph1);
        sb_off = 1'b0;
        repeat (3) @(negedge eph1);
        run_txn(2'd1, 2, 1, 0, 1'b1, 1'b0);
        wait_quiet();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
